// File: rtl/des_key_schedule_if.sv
// Handshake bundle between a DES key-schedule requester (master) and the
// schedule generator (slave).
interface des_key_schedule_if;
    logic        start;
    logic        decrypt;
    logic [64:1] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [48:1] subkey;
    logic [5:1]  subkey_round;
    logic        done;

    modport master (
        output start, decrypt, key, subkey_ready,
        input  busy, subkey_valid, subkey, subkey_round, done
    );

    modport slave (
        input  start, decrypt, key, subkey_ready,
        output busy, subkey_valid, subkey, subkey_round, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 once, then one rotate + PC-2 per accepted
// subkey, K1..K16 in encrypt mode or K16..K1 in decrypt mode.

module left_shift (
    input  logic [28:1] din,
    input  logic        two,
    output logic [28:1] dout
);
    assign dout = two ? {din[26:1], din[28:27]} : {din[27:1], din[28]};
endmodule

module des_key_schedule (
    input  logic                  clk,
    input  logic                  rst_n,
    des_key_schedule_if.slave     bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    // FIPS 46 tables; entry n gives the source bit (1 = MSB) of output bit n+1.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q, state_d;
    logic [28:1] c_half_q, c_half_d;
    logic [28:1] d_half_q, d_half_d;
    logic [5:1]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [48:1] subkey_q, subkey_d;
    logic [5:1]  round_q, round_d;

    logic [56:1] pc1_key;
    logic [56:1] pc2_in;
    logic [48:1] pc2_out;
    logic [28:1] c_rotl, d_rotl, c_rotr, d_rotr;
    logic        two_step;
    logic        advance;

    // Parity bits never reach PC-1.
    wire unused_parity = &{1'b0, bus.key[57], bus.key[49], bus.key[41], bus.key[33],
                           bus.key[25], bus.key[17], bus.key[9], bus.key[1]};

    // Vector index i holds FIPS bit (width+1-i), hence the reversed indexing.
    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[56-gi] = bus.key[65-PC1_TAB[gi]];
        end
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_out[48-gi] = pc2_in[57-PC2_TAB[gi]];
        end
    endgenerate

    assign two_step = !((cnt_q == 5'd1) || (cnt_q == 5'd2) ||
                        (cnt_q == 5'd9) || (cnt_q == 5'd16));

    left_shift u_rotl_c (.din(c_half_q), .two(two_step), .dout(c_rotl));
    left_shift u_rotl_d (.din(d_half_q), .two(two_step), .dout(d_rotl));

    assign c_rotr = two_step ? {c_half_q[2:1], c_half_q[28:3]} : {c_half_q[1], c_half_q[28:2]};
    assign d_rotr = two_step ? {d_half_q[2:1], d_half_q[28:3]} : {d_half_q[1], d_half_q[28:2]};

    // Encrypt rotates before PC-2; decrypt uses the halves as stored, then rotates back.
    assign pc2_in  = dec_q ? {c_half_q, d_half_q} : {c_rotl, d_rotl};
    assign advance = !valid_q || bus.subkey_ready;

    always_comb begin
        state_d  = state_q;
        c_half_d = c_half_q;
        d_half_d = d_half_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        subkey_d = subkey_q;
        round_d  = round_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    c_half_d = pc1_key[56:29];
                    d_half_d = pc1_key[28:1];
                    dec_d    = bus.decrypt;
                    cnt_d    = bus.decrypt ? 5'd16 : 5'd1;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    subkey_d = pc2_out;
                    round_d  = cnt_q;
                    valid_d  = 1'b1;
                    if (dec_q) begin
                        c_half_d = c_rotr;
                        d_half_d = d_rotr;
                        cnt_d    = cnt_q - 5'd1;
                        if (cnt_q == 5'd1) state_d = ST_FIN;
                    end else begin
                        c_half_d = c_rotl;
                        d_half_d = d_rotl;
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == 5'd16) state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                if (bus.subkey_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            c_half_q <= '0;
            d_half_q <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            subkey_q <= '0;
            round_q  <= '0;
        end else begin
            state_q  <= state_d;
            c_half_q <= c_half_d;
            d_half_q <= d_half_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.subkey_valid = valid_q;
    assign bus.done         = done_q;
    assign bus.subkey       = subkey_q;
    assign bus.subkey_round = round_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1
// key and its published round keys.
module tb_des_key_schedule;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_key_schedule_if bus();
    des_key_schedule dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [5:1]  round;
        logic [48:1] subkey;
    } vec_t;

    localparam logic [64:1] KEY = 64'h133457799BBCDFF1;

    vec_t vecs [16];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({bus.busy, bus.subkey_valid, bus.done, bus.subkey_round, bus.subkey}), 64'd0);
    endtask

    task automatic do_start(input logic [64:1] k, input logic dec);
        bus.key     = k;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.key     = ~k;
        bus.decrypt = ~dec;
    endtask

    // Cycle-exact run: stall_n ready-low cycles on stall_round, start pulse on glitch_round.
    task automatic run_check(input logic dec, input logic [64:1] k,
                             input int stall_round, input int stall_n, input int glitch_round);
        int idx;
        int hold;
        do_start(k, dec);
        @(negedge clk);
        check("cycle1_flags", 64'({bus.busy, bus.subkey_valid, bus.done}), 64'd4);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idx  = dec ? 15 - i : i;
            hold = (int'(vecs[idx].round) == stall_round) ? stall_n : 0;
            for (int s = 0; s <= hold; s++) begin
                if (s > 0) @(negedge clk);
                bus.subkey_ready = (s == hold);
                if (int'(vecs[idx].round) == glitch_round && s == 0) begin
                    bus.start   = 1'b1;
                    bus.key     = 64'h0123456789ABCDEF;
                    bus.decrypt = ~dec;
                end else begin
                    bus.start = 1'b0;
                end
                check("run_flags", 64'({bus.busy, bus.subkey_valid, bus.done}), 64'd6);
                check("round", 64'(bus.subkey_round), 64'(vecs[idx].round));
                check("subkey", 64'(bus.subkey), 64'(vecs[idx].subkey));
            end
            $display("txn dec=%0d round=%0d subkey=%h", dec, bus.subkey_round, bus.subkey);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_flags", 64'({bus.busy, bus.subkey_valid, bus.done}), 64'd1);
        @(negedge clk);
        check("done_pulse", 64'({bus.busy, bus.subkey_valid, bus.done}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        vecs[0]  = '{5'd1,  48'h1B02EFFC7072};
        vecs[1]  = '{5'd2,  48'h79AED9DBC9E5};
        vecs[2]  = '{5'd3,  48'h55FC8A42CF99};
        vecs[3]  = '{5'd4,  48'h72ADD6DB351D};
        vecs[4]  = '{5'd5,  48'h7CEC07EB53A8};
        vecs[5]  = '{5'd6,  48'h63A53E507B2F};
        vecs[6]  = '{5'd7,  48'hEC84B7F618BC};
        vecs[7]  = '{5'd8,  48'hF78A3AC13BFB};
        vecs[8]  = '{5'd9,  48'hE0DBEBEDE781};
        vecs[9]  = '{5'd10, 48'hB1F347BA464F};
        vecs[10] = '{5'd11, 48'h215FD3DED386};
        vecs[11] = '{5'd12, 48'h7571F59467E9};
        vecs[12] = '{5'd13, 48'h97C5D1FABA41};
        vecs[13] = '{5'd14, 48'h5F43B7F2E73A};
        vecs[14] = '{5'd15, 48'hBF918D3D3F0A};
        vecs[15] = '{5'd16, 48'hCB3D8B0E17F5};

        bus.start        = 1'b0;
        bus.decrypt      = 1'b0;
        bus.key          = '0;
        bus.subkey_ready = 1'b1;
        rst_n            = 1'b1;

        // Asynchronous reset between edges, then idle with start low.
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_zero("idle_zero");
        end

        run_check(1'b0, KEY, 0, 0, 0);
        run_check(1'b1, KEY, 0, 0, 0);
        run_check(1'b0, KEY, 2, 3, 0);

        // Reset while round 7 is on the output, then a clean rerun from K1.
        do_start(KEY, 1'b0);
        @(negedge clk);
        check("c0_half", 64'(dut.c_half_q), 64'h0F0CCAAF);
        check("d0_half", 64'(dut.d_half_q), 64'h0556678F);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (bus.subkey_valid && bus.subkey_round == 5'd7) found = 1'b1;
        end
        check("round7_seen", 64'(found), 64'd1);
        check("round7_key", 64'(bus.subkey), 64'(vecs[6].subkey));
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midrun");
        @(negedge clk);
        check_zero("reset_held");
        rst_n = 1'b1;
        run_check(1'b0, KEY, 0, 0, 0);

        run_check(1'b0, KEY, 0, 0, 5);
        run_check(1'b0, KEY ^ 64'h0101010101010101, 0, 0, 0);
        run_check(1'b1, KEY ^ 64'h0101010101010101, 10, 2, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
